// File: rtl/wb2_load_buffer.sv
// wb2_load_buffer: one-entry second-writeback buffer for delayed writes.
// It handles loads through a req/gnt/rvalid handshake with data memory, and
// bcnv results through a wait on BNN completion. It extends and aligns the
// returned data, then drives the register file's second write port.
//
// state | meaning
// IDLE  | empty, ready to accept
// REQ   | load request held on memory port until granted
// WAIT  | waiting for mem_rvalid (load) or bnn_done (bcnv)
// WRITE | one-cycle write on the second port; may accept the next op
module wb2_load_buffer (
  input  logic        clk,
  input  logic        reset,
  input  logic        RegWE_W_W,
  input  logic [1:0]  ExPathW,
  input  logic [4:0]  A3_W,
  input  logic [2:0]  funct3W,
  input  logic [31:0] AddrW,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  input  logic        bnn_done,
  input  logic [31:0] bnn_result,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic        RegWE_W_W2,
  output logic [4:0]  A4_W2,
  output logic [31:0] WD4_W2,
  output logic [1:0]  ExPathW2,
  output logic        BusyW2
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, WRITE} state_t;

  localparam logic [1:0] PATH_LOAD = 2'b01;
  localparam logic [1:0] PATH_BCNV = 2'b10;

  state_t      state_q, state_d;
  logic [1:0]  path_q;
  logic [4:0]  dest_q;
  logic [2:0]  funct3_q;
  logic [1:0]  off_q;
  logic [29:0] word_addr_q;
  logic [31:0] wd_q;

  logic        accept;
  logic        capture_load;
  logic        capture_bcnv;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_ext;

  // Only real delayed-write paths are taken; 00/11 never reach this stage.
  assign accept = RegWE_W_W && (state_q == IDLE || state_q == WRITE) &&
                  (ExPathW == PATH_LOAD || ExPathW == PATH_BCNV);

  // Responses from the source not owning the op are ignored.
  assign capture_load = (state_q == WAIT) && (path_q == PATH_LOAD) && mem_rvalid;
  assign capture_bcnv = (state_q == WAIT) && (path_q == PATH_BCNV) && bnn_done;

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) state_d = (ExPathW == PATH_LOAD) ? REQ : WAIT;
      end
      REQ: begin
        if (mem_gnt) state_d = WAIT;
      end
      WAIT: begin
        if (capture_load || capture_bcnv) state_d = WRITE;
      end
      WRITE: begin
        if (accept) state_d = (ExPathW == PATH_LOAD) ? REQ : WAIT;
        else        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Load extension from the live read word using the latched size and offset.
  always_comb begin
    byte_sel = mem_rdata[{off_q, 3'b000} +: 8];
    half_sel = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (funct3_q)
      3'b000:  load_ext = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  load_ext = {{16{half_sel[15]}}, half_sel};
      3'b100:  load_ext = {24'h000000, byte_sel};
      3'b101:  load_ext = {16'h0000, half_sel};
      default: load_ext = mem_rdata;
    endcase
  end

  // State register, op latch on accept, and write data capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      path_q      <= 2'b00;
      dest_q      <= 5'd0;
      funct3_q    <= 3'b000;
      off_q       <= 2'b00;
      word_addr_q <= 30'd0;
      wd_q        <= 32'd0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        path_q      <= ExPathW;
        dest_q      <= A3_W;
        funct3_q    <= funct3W;
        off_q       <= AddrW[1:0];
        word_addr_q <= AddrW[31:2];
      end
      if (capture_load) wd_q <= load_ext;
      if (capture_bcnv) wd_q <= bnn_result;
    end
  end

  assign mem_req    = (state_q == REQ);
  assign mem_addr   = {word_addr_q, 2'b00};
  assign BusyW2     = (state_q == REQ) || (state_q == WAIT);
  // x0 destinations finish the handshake but never write.
  assign RegWE_W_W2 = (state_q == WRITE) && (dest_q != 5'd0);
  assign A4_W2      = (state_q == IDLE) ? 5'd0 : dest_q;
  assign ExPathW2   = (state_q == IDLE) ? 2'b00 : path_q;
  assign WD4_W2     = wd_q;

  // Upstream must hold the Writeback op steady while this buffer is busy.
  a_dest_stable_while_busy : assert property (
    @(posedge clk) disable iff (reset)
    (BusyW2 && RegWE_W_W && $past(BusyW2 && RegWE_W_W)) |-> $stable(A3_W)
  );

endmodule

// File: tb/tb_wb2_load_buffer.sv
// tb_wb2_load_buffer: directed plus randomized checks of wb2_load_buffer
// against an arithmetic reference model of load extension and op latency.
module tb_wb2_load_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic        RegWE_W_W;
  logic [1:0]  ExPathW;
  logic [4:0]  A3_W;
  logic [2:0]  funct3W;
  logic [31:0] AddrW;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        bnn_done;
  logic [31:0] bnn_result;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        RegWE_W_W2;
  logic [4:0]  A4_W2;
  logic [31:0] WD4_W2;
  logic [1:0]  ExPathW2;
  logic        BusyW2;

  int vectors = 0;
  int miscompares = 0;

  wb2_load_buffer dut (
    .clk        (clk),
    .reset      (reset),
    .RegWE_W_W  (RegWE_W_W),
    .ExPathW    (ExPathW),
    .A3_W       (A3_W),
    .funct3W    (funct3W),
    .AddrW      (AddrW),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .bnn_done   (bnn_done),
    .bnn_result (bnn_result),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .RegWE_W_W2 (RegWE_W_W2),
    .A4_W2      (A4_W2),
    .WD4_W2     (WD4_W2),
    .ExPathW2   (ExPathW2),
    .BusyW2     (BusyW2)
  );

  always #5 clk = ~clk;

  // Reference extension: pick the lane by shifting, sign-extend by arithmetic.
  function automatic logic [31:0] model_ext(input logic [2:0] f3, input logic [1:0] off,
                                            input logic [31:0] w);
    logic [31:0] b;
    logic [31:0] h;
    b = (w >> (8 * int'(off))) & 32'h0000_00FF;
    h = (w >> (16 * (int'(off) / 2))) & 32'h0000_FFFF;
    case (f3)
      3'd0:    return (b >= 32'd128)   ? b + 32'hFFFF_FF00 : b;
      3'd1:    return (h >= 32'd32768) ? h + 32'hFFFF_0000 : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return w;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    RegWE_W_W = 1'b0;
    step();
    chk({tag, "_we"},   32'(RegWE_W_W2), 32'd0);
    chk({tag, "_busy"}, 32'(BusyW2),     32'd0);
    chk({tag, "_req"},  32'(mem_req),    32'd0);
    chk({tag, "_path"}, 32'(ExPathW2),   32'd0);
    chk({tag, "_a4"},   32'(A4_W2),      32'd0);
  endtask

  // Accept a load in the current cycle; returns positioned in its WRITE cycle.
  task automatic run_load(input logic [4:0] rd, input logic [31:0] addr, input logic [2:0] f3,
                          input int gnt_dly, input int rv_dly, input logic [31:0] data,
                          input bit junk);
    logic [31:0] exp_wd;
    exp_wd = model_ext(f3, addr[1:0], data);
    RegWE_W_W = 1'b1; ExPathW = 2'b01; A3_W = rd; funct3W = f3; AddrW = addr;
    step();
    RegWE_W_W = 1'b0; AddrW = $urandom; funct3W = 3'($urandom_range(0, 7));
    chk("ld_req",  32'(mem_req), 32'd1);
    chk("ld_addr", mem_addr, addr & ~32'h3);
    chk("ld_busy", 32'(BusyW2), 32'd1);
    for (int i = 0; i < gnt_dly; i++) begin
      mem_rvalid = junk; mem_rdata = $urandom;
      step();
      chk("ld_req_hold",  32'(mem_req), 32'd1);
      chk("ld_addr_hold", mem_addr, addr & ~32'h3);
    end
    mem_gnt = 1'b1; mem_rvalid = junk; mem_rdata = ~data;
    step();
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    chk("ld_wait_req",  32'(mem_req), 32'd0);
    chk("ld_wait_busy", 32'(BusyW2),  32'd1);
    for (int i = 0; i < rv_dly; i++) begin
      bnn_done = junk; bnn_result = $urandom;
      step();
      chk("ld_wait_busy2", 32'(BusyW2), 32'd1);
    end
    bnn_done = 1'b0; mem_rvalid = 1'b1; mem_rdata = data;
    step();
    mem_rvalid = 1'b0; mem_rdata = $urandom;
    chk("ld_we",   32'(RegWE_W_W2), 32'(rd != 5'd0));
    chk("ld_a4",   32'(A4_W2), 32'(rd));
    chk("ld_wd",   WD4_W2, exp_wd);
    chk("ld_path", 32'(ExPathW2), 32'd1);
    chk("ld_busy_wr", 32'(BusyW2), 32'd0);
  endtask

  // Accept a bcnv in the current cycle; bnn_done arrives k cycles after accept.
  task automatic run_bcnv(input logic [4:0] rd, input int k, input logic [31:0] data,
                          input bit junk);
    RegWE_W_W = 1'b1; ExPathW = 2'b10; A3_W = rd; funct3W = 3'($urandom_range(0, 7));
    AddrW = $urandom;
    step();
    RegWE_W_W = 1'b0;
    chk("bc_busy", 32'(BusyW2), 32'd1);
    chk("bc_req",  32'(mem_req), 32'd0);
    chk("bc_path", 32'(ExPathW2), 32'd2);
    for (int i = 1; i < k; i++) begin
      mem_rvalid = junk; mem_rdata = $urandom;
      step();
      chk("bc_req_wait",  32'(mem_req), 32'd0);
      chk("bc_busy_wait", 32'(BusyW2), 32'd1);
    end
    mem_rvalid = 1'b0; bnn_done = 1'b1; bnn_result = data;
    step();
    bnn_done = 1'b0; bnn_result = $urandom;
    chk("bc_we",   32'(RegWE_W_W2), 32'(rd != 5'd0));
    chk("bc_a4",   32'(A4_W2), 32'(rd));
    chk("bc_wd",   WD4_W2, data);
    chk("bc_path_wr", 32'(ExPathW2), 32'd2);
    chk("bc_req_wr",  32'(mem_req), 32'd0);
  endtask

  initial begin
    reset = 1'b1; RegWE_W_W = 1'b0; ExPathW = 2'b00; A3_W = 5'd0; funct3W = 3'd0;
    AddrW = 32'd0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'd0;
    bnn_done = 1'b0; bnn_result = 32'd0;
    step();
    step();
    chk("rst_req",  32'(mem_req), 32'd0);
    chk("rst_we",   32'(RegWE_W_W2), 32'd0);
    chk("rst_busy", 32'(BusyW2), 32'd0);
    chk("rst_path", 32'(ExPathW2), 32'd0);
    chk("rst_a4",   32'(A4_W2), 32'd0);
    chk("rst_wd",   WD4_W2, 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    reset = 1'b0;
    step();

    // LW with grant after two REQ cycles and a delayed response.
    run_load(5'd5, 32'h0000_0104, 3'b010, 2, 2, 32'hDEAD_BEEF, 1'b0);
    check_idle("lw_idle");

    // Extension cases on a single read word.
    run_load(5'd1, 32'h0000_1000, 3'b000, 0, 0, 32'h80F1_7F82, 1'b0);
    check_idle("lb_idle");
    run_load(5'd2, 32'h0000_1003, 3'b100, 1, 0, 32'h80F1_7F82, 1'b1);
    check_idle("lbu_idle");
    run_load(5'd3, 32'h0000_1002, 3'b001, 0, 1, 32'h80F1_7F82, 1'b0);
    check_idle("lh_idle");
    run_load(5'd4, 32'h0000_1000, 3'b101, 0, 0, 32'h80F1_7F82, 1'b1);
    check_idle("lhu_idle");

    // bcnv with bnn_done four cycles after accept.
    run_bcnv(5'd9, 4, 32'h0000_0017, 1'b1);
    check_idle("bc_idle");

    // Back-to-back: second load accepted in the first one's WRITE cycle.
    run_load(5'd10, 32'h0000_2000, 3'b010, 0, 0, 32'h1234_5678, 1'b0);
    run_load(5'd11, 32'h0000_2004, 3'b010, 1, 1, 32'h9ABC_DEF0, 1'b0);
    check_idle("b2b_idle");

    // Load to x0 completes without a write.
    run_load(5'd0, 32'h0000_3000, 3'b010, 0, 0, 32'hCAFE_F00D, 1'b0);
    check_idle("x0_idle");

    // Reset during WAIT abandons the load; a stale response afterwards is dropped.
    RegWE_W_W = 1'b1; ExPathW = 2'b01; A3_W = 5'd7; funct3W = 3'b010; AddrW = 32'h0000_0200;
    step();
    RegWE_W_W = 1'b0; mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    chk("mrst_busy", 32'(BusyW2), 32'd1);
    reset = 1'b1;
    step();
    chk("mrst_we1", 32'(RegWE_W_W2), 32'd0);
    step();
    chk("mrst_we2", 32'(RegWE_W_W2), 32'd0);
    reset = 1'b0;
    chk("mrst_busy0", 32'(BusyW2), 32'd0);
    chk("mrst_path",  32'(ExPathW2), 32'd0);
    chk("mrst_a4",    32'(A4_W2), 32'd0);
    chk("mrst_wd",    WD4_W2, 32'd0);
    chk("mrst_addr",  mem_addr, 32'd0);
    chk("mrst_req",   32'(mem_req), 32'd0);
    mem_rvalid = 1'b1; mem_rdata = 32'h5555_AAAA;
    step();
    mem_rvalid = 1'b0;
    chk("stale_we",   32'(RegWE_W_W2), 32'd0);
    chk("stale_busy", 32'(BusyW2), 32'd0);
    chk("stale_wd",   WD4_W2, 32'd0);
    check_idle("stale_idle");

    // Randomized mix of loads and bcnv, some back-to-back.
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 2) == 2)
        run_bcnv(5'($urandom_range(0, 31)), int'($urandom_range(1, 5)), $urandom,
                 1'($urandom_range(0, 1)));
      else
        run_load(5'($urandom_range(0, 31)), $urandom, 3'($urandom_range(0, 7)),
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), $urandom,
                 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) check_idle("rnd_idle");
    end
    check_idle("end_idle");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
